// File: rtl/mul8_quad_sched_pkg.sv
// Shared types and helpers for the quadrant-scheduled 8x8 multiplier.
// Quadrant order is LL, LH, HL, HH; the index doubles as the cfg bit.
package mul8_quad_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  localparam int NIB_W   = 4;
  localparam int PROD4_W = 8;
  localparam int PROD8_W = 16;

  localparam logic [1:0] Q_LL = 2'd0;
  localparam logic [1:0] Q_LH = 2'd1;
  localparam logic [1:0] Q_HL = 2'd2;
  localparam logic [1:0] Q_HH = 2'd3;

  localparam logic [3:0] SHIFT_TAB [4] = '{4'd0, 4'd4, 4'd4, 4'd8};

  function automatic logic [3:0] shift_of(input logic [1:0] q);
    return SHIFT_TAB[q];
  endfunction

  // Quadrants worth running; zero nibbles contribute nothing.
  function automatic logic [3:0] quad_mask(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       skip
  );
    logic la, ha, lb, hb;
    la = |a[3:0];
    ha = |a[7:4];
    lb = |b[3:0];
    hb = |b[7:4];
    if (!skip) return 4'hF;
    return {ha & hb, ha & lb, la & hb, la & lb};
  endfunction

  // Lowest active quadrant at or above 'from'; 4 means none left.
  function automatic logic [2:0] scan_from(
    input logic [3:0] m,
    input logic [2:0] from
  );
    logic [2:0] r;
    r = 3'd4;
    for (int j = 3; j >= 0; j--) begin
      if (j >= int'(from) && m[j]) r = 3'(j);
    end
    return r;
  endfunction

endpackage

// File: rtl/mul8_quad_sched_pick.sv
// Quadrant selector: nibbles, shift and next active index.
// Purely combinational, driven from the latched operation.
module mul8_quad_pick
  import mul8_quad_sched_pkg::*;
(
  input  logic [7:0]       a_i,
  input  logic [7:0]       b_i,
  input  logic [3:0]       mask_i,
  input  logic [1:0]       idx_i,
  output logic [NIB_W-1:0] nib_a_o,
  output logic [NIB_W-1:0] nib_b_o,
  output logic [3:0]       shift_o,
  output logic [2:0]       next_o,
  output logic             last_o
);

  // Route the nibbles of the current quadrant and look ahead.
  always_comb begin
    nib_a_o = a_i[3:0];
    nib_b_o = b_i[3:0];
    unique case (idx_i)
      Q_LL: begin
        nib_a_o = a_i[3:0];
        nib_b_o = b_i[3:0];
      end
      Q_LH: begin
        nib_a_o = a_i[3:0];
        nib_b_o = b_i[7:4];
      end
      Q_HL: begin
        nib_a_o = a_i[7:4];
        nib_b_o = b_i[3:0];
      end
      Q_HH: begin
        nib_a_o = a_i[7:4];
        nib_b_o = b_i[7:4];
      end
      default: ;
    endcase
    shift_o = shift_of(idx_i);
    next_o  = scan_from(mask_i, {1'b0, idx_i} + 3'd1);
    last_o  = next_o[2];
  end

endmodule

// File: rtl/mul8_quad_sched.sv
// 8x8 multiplier sequencing four 4x4 quadrant products
// through one external shared unit, with zero-quadrant skipping.
module mul8_quad_sched
  import mul8_quad_sched_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_a,
  input  logic [7:0]         in_b,
  input  logic [3:0]         in_cfg,
  output logic               mul_en,
  output logic [NIB_W-1:0]   mul_a,
  output logic [NIB_W-1:0]   mul_b,
  output logic               mul_approx,
  input  logic [PROD4_W-1:0] mul_prod,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PROD8_W-1:0] out_prod,
  output logic               busy
);

  state_e state_q, state_d;

  logic [7:0]         a_q, b_q;
  logic [3:0]         cfg_q, mask_q;
  logic [1:0]         idx_q;
  logic [PROD8_W-1:0] acc_q, out_prod_q;

  logic               accept;
  logic [3:0]         mask_in;
  logic [2:0]         first;
  logic [NIB_W-1:0]   nib_a, nib_b;
  logic [3:0]         shift;
  logic [2:0]         nxt;
  logic               last;
  logic [PROD8_W-1:0] sum;

  mul8_quad_pick u_pick (
    .a_i     (a_q),
    .b_i     (b_q),
    .mask_i  (mask_q),
    .idx_i   (idx_q),
    .nib_a_o (nib_a),
    .nib_b_o (nib_b),
    .shift_o (shift),
    .next_o  (nxt),
    .last_o  (last)
  );

  assign mask_in = quad_mask(in_a, in_b, SKIP_ZERO);
  assign first   = scan_from(mask_in, 3'd0);
  assign accept  = in_valid && in_ready;
  assign sum     = acc_q + (PROD8_W'(mul_prod) << shift);
  assign out_prod = out_prod_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: skip straight to DONE when nothing is active.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = first[2] ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        if (accept)         state_d = first[2] ? S_DONE : S_CALC;
        else if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and shared-unit drive; unit is idle outside CALC.
  always_comb begin
    in_ready   = (state_q == S_IDLE) ||
                 (state_q == S_DONE && out_ready);
    out_valid  = (state_q == S_DONE);
    busy       = (state_q == S_CALC);
    mul_en     = busy;
    mul_a      = busy ? nib_a : '0;
    mul_b      = busy ? nib_b : '0;
    mul_approx = busy ? cfg_q[idx_q] : 1'b0;
  end

  // Operand latch and shift-accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      cfg_q      <= '0;
      mask_q     <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      out_prod_q <= '0;
    end else if (accept) begin
      a_q    <= in_a;
      b_q    <= in_b;
      cfg_q  <= in_cfg;
      mask_q <= mask_in;
      idx_q  <= first[1:0];
      acc_q  <= '0;
      if (first[2]) out_prod_q <= '0;
    end else if (state_q == S_CALC) begin
      acc_q <= sum;
      if (last) out_prod_q <= sum;
      else      idx_q      <= nxt[1:0];
    end
  end

endmodule
